// File: rtl/dmem_pkg.sv
// Shared types for the RV32 data memory: funct3 codes, FSM states and the alignment rule.
package dmem_pkg;

    typedef enum logic [2:0] {
        LB  = 3'd0,
        LH  = 3'd1,
        LW  = 3'd2,
        LBU = 3'd4,
        LHU = 3'd5
    } load_f3_e;

    typedef enum logic [2:0] {
        SB = 3'd0,
        SH = 3'd1,
        SW = 3'd2
    } store_f3_e;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_e;

    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;

    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lane);
        return ((size == SIZE_H) && lane[0]) || ((size == SIZE_W) && (lane != 2'b00));
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane steering: store byte-enables and data replication, load lane select with
// sign/zero extension, and the misaligned/illegal access flag.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic        we_i,
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  lane_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rword_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o,
    output logic        err_o
);

    logic        illegal;
    logic [7:0]  rbyte;
    logic [15:0] rhalf;

    always_comb begin
        illegal = we_i ? (funct3_i > 3'd2)
                       : ((funct3_i == 3'd3) || (funct3_i == 3'd6) || (funct3_i == 3'd7));
        err_o   = illegal || misaligned(funct3_i[1:0], lane_i);
        case (lane_i)
            2'd0:    rbyte = rword_i[7:0];
            2'd1:    rbyte = rword_i[15:8];
            2'd2:    rbyte = rword_i[23:16];
            default: rbyte = rword_i[31:24];
        endcase
        rhalf   = lane_i[1] ? rword_i[31:16] : rword_i[15:0];
        be_o    = 4'b0000;
        wdata_o = wdata_i;
        rdata_o = 32'd0;
        // Errored accesses leave byte-enables and load data at zero.
        if (!err_o) begin
            if (we_i) begin
                case (funct3_i)
                    SB: begin
                        be_o    = 4'b0001 << lane_i;
                        wdata_o = {4{wdata_i[7:0]}};
                    end
                    SH: begin
                        be_o    = lane_i[1] ? 4'b1100 : 4'b0011;
                        wdata_o = {2{wdata_i[15:0]}};
                    end
                    default: be_o = 4'b1111;
                endcase
            end else begin
                case (funct3_i)
                    LB:      rdata_o = {{24{rbyte[7]}}, rbyte};
                    LH:      rdata_o = {{16{rhalf[15]}}, rhalf};
                    LBU:     rdata_o = {24'd0, rbyte};
                    LHU:     rdata_o = {16'd0, rhalf};
                    default: rdata_o = rword_i;
                endcase
            end
        end
    end

endmodule

// File: rtl/dmem_lsu_ram.sv
// RV32 data memory with LSU front end, valid/ready request port and programmable wait states.
// Optional registered debug read port enabled by defining DMEM_DEBUG_PORT_EN.
module dmem_lsu_ram
    import dmem_pkg::*;
#(
    parameter int ADDR_WIDTH  = 12,
    parameter int WAIT_CYCLES = 0
) (
    input  logic                  CLK,
    input  logic                  RESET_N,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [2:0]            req_funct3,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  rsp_valid,
    output logic [31:0]           rsp_rdata,
    output logic                  rsp_err
`ifdef DMEM_DEBUG_PORT_EN
    ,
    input  logic [ADDR_WIDTH-3:0] dbg_addr,
    output logic [31:0]           dbg_rdata
`endif
);

    localparam int         DEPTH    = 2 ** (ADDR_WIDTH - 2);
    localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    state_e                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  we_q;
    logic [2:0]            funct3_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [31:0]           wdata_q;
    logic [31:0]           rsp_rdata_q;
    logic                  rsp_err_q;
    logic                  accept, commit;
    logic                  acc_we;
    logic [2:0]            acc_funct3;
    logic [ADDR_WIDTH-1:0] acc_addr;
    logic [31:0]           acc_wdata;
    logic [3:0]            al_be;
    logic [31:0]           al_wdata, al_rdata;
    logic                  al_err;
    logic [31:0]           mem_q [DEPTH];

    // With no wait states the access commits on the accept edge, so it must see the live request.
    assign acc_we     = (state_q == IDLE) ? req_we     : we_q;
    assign acc_funct3 = (state_q == IDLE) ? req_funct3 : funct3_q;
    assign acc_addr   = (state_q == IDLE) ? req_addr   : addr_q;
    assign acc_wdata  = (state_q == IDLE) ? req_wdata  : wdata_q;

    dmem_lane_align u_align (
        .we_i     (acc_we),
        .funct3_i (acc_funct3),
        .lane_i   (acc_addr[1:0]),
        .wdata_i  (acc_wdata),
        .rword_i  (mem_q[acc_addr[ADDR_WIDTH-1:2]]),
        .be_o     (al_be),
        .wdata_o  (al_wdata),
        .rdata_o  (al_rdata),
        .err_o    (al_err)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        commit  = 1'b0;
        accept  = req_valid && (state_q == IDLE);
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (WAIT_CYCLES == 0) begin
                        state_d = RESP;
                        commit  = 1'b1;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = RESP;
                    commit  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            we_q        <= 1'b0;
            funct3_q    <= 3'd0;
            addr_q      <= '0;
            wdata_q     <= 32'd0;
            rsp_rdata_q <= 32'd0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                we_q     <= req_we;
                funct3_q <= req_funct3;
                addr_q   <= req_addr;
                wdata_q  <= req_wdata;
            end
            if (commit) begin
                rsp_rdata_q <= acc_we ? 32'd0 : al_rdata;
                rsp_err_q   <= al_err;
            end
        end
    end

    // Array is never reset; a reset on the commit edge abandons the write.
    always_ff @(posedge CLK) begin
        if (RESET_N && commit && acc_we) begin
            for (int b = 0; b < 4; b++) begin
                if (al_be[b]) begin
                    mem_q[acc_addr[ADDR_WIDTH-1:2]][8*b +: 8] <= al_wdata[8*b +: 8];
                end
            end
        end
    end

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

`ifdef DMEM_DEBUG_PORT_EN
    logic [31:0] dbg_rdata_q;

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            dbg_rdata_q <= 32'd0;
        end else begin
            dbg_rdata_q <= mem_q[dbg_addr];
        end
    end

    assign dbg_rdata = dbg_rdata_q;
`endif

endmodule

// File: tb/tb_dmem_lsu_ram.sv
// Bench for dmem_lsu_ram: two instances (0 and 3 wait states) share one request stream and are
// checked against a byte-array reference model. Exercises the debug port when DMEM_DEBUG_PORT_EN is set.
module tb_dmem_lsu_ram;

    localparam int         W0 = 0;
    localparam int         W3 = 3;
    localparam logic [2:0] F_B = 3'd0, F_H = 3'd1, F_W = 3'd2, F_BU = 3'd4, F_HU = 3'd5;

    logic        CLK = 1'b0;
    logic        RESET_N;
    logic        reqValid, reqWe;
    logic [2:0]  reqFunct3;
    logic [11:0] reqAddr;
    logic [31:0] reqWdata;
    logic        ready0, valid0, err0, ready3, valid3, err3;
    logic [31:0] rdata0, rdata3;

    int          compared   = 0;
    int          mismatched = 0;
    logic [7:0]  mdl [2][4096];

`ifdef DMEM_DEBUG_PORT_EN
    logic [9:0]  dbgAddr;
    logic [31:0] dbgRdata0, dbgRdata3;
    logic [31:0] dbgS0 [16];
    logic [31:0] dbgS3 [16];
`endif

    always #5 CLK = ~CLK;

    dmem_lsu_ram #(.ADDR_WIDTH(12), .WAIT_CYCLES(W0)) dut0 (
        .CLK(CLK), .RESET_N(RESET_N), .req_valid(reqValid), .req_ready(ready0), .req_we(reqWe),
        .req_funct3(reqFunct3), .req_addr(reqAddr), .req_wdata(reqWdata),
        .rsp_valid(valid0), .rsp_rdata(rdata0), .rsp_err(err0)
`ifdef DMEM_DEBUG_PORT_EN
        , .dbg_addr(dbgAddr), .dbg_rdata(dbgRdata0)
`endif
    );

    dmem_lsu_ram #(.ADDR_WIDTH(12), .WAIT_CYCLES(W3)) dut3 (
        .CLK(CLK), .RESET_N(RESET_N), .req_valid(reqValid), .req_ready(ready3), .req_we(reqWe),
        .req_funct3(reqFunct3), .req_addr(reqAddr), .req_wdata(reqWdata),
        .rsp_valid(valid3), .rsp_rdata(rdata3), .rsp_err(err3)
`ifdef DMEM_DEBUG_PORT_EN
        , .dbg_addr(dbgAddr), .dbg_rdata(dbgRdata3)
`endif
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic mdlErr(input logic we, input logic [2:0] f3, input logic [11:0] addr);
        int size = int'(f3) % 4;
        if (we && f3 > 3'd2) return 1'b1;
        if (!we && (f3 == 3'd3 || f3 >= 3'd6)) return 1'b1;
        if (size == 1 && int'(addr) % 2 != 0) return 1'b1;
        if (size == 2 && int'(addr) % 4 != 0) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] mdlLoad(input int d, input logic [2:0] f3, input logic [11:0] addr);
        int          n = 1 << (int'(f3) % 4);
        logic [31:0] v = 32'd0;
        for (int i = 0; i < n; i++) v = v | (32'(mdl[d][int'(addr) + i]) << (8 * i));
        if (f3 < 3'd4 && n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8 * n)) - 32'd1);
        return v;
    endfunction

    // One request to both instances; measures latency, pulse count, data and error against the model.
    task automatic applyStimulus(input logic we, input logic [2:0] f3, input logic [11:0] addr,
                                 input logic [31:0] wd, input string tag,
                                 output logic [31:0] obs0, output logic [31:0] obs3);
        logic [31:0] exp0, exp3, rd0, rd3;
        logic        expErr, er0, er3;
        int          lat0, lat3, pulses0, pulses3;
        expErr = mdlErr(we, f3, addr);
        exp0   = (we || expErr) ? 32'd0 : mdlLoad(0, f3, addr);
        exp3   = (we || expErr) ? 32'd0 : mdlLoad(1, f3, addr);
        checkOutput({tag, "/ready0"}, 32'(ready0), 32'd1);
        checkOutput({tag, "/ready3"}, 32'(ready3), 32'd1);
        reqValid  = 1'b1;
        reqWe     = we;
        reqFunct3 = f3;
        reqAddr   = addr;
        reqWdata  = wd;
        @(negedge CLK);
        reqValid  = 1'b0;
        reqWe     = 1'($urandom);
        reqFunct3 = 3'($urandom);
        reqAddr   = 12'($urandom);
        reqWdata  = $urandom;
        lat0 = 0; lat3 = 0; pulses0 = 0; pulses3 = 0;
        rd0 = 32'hx; rd3 = 32'hx; er0 = 1'bx; er3 = 1'bx;
        for (int k = 1; k <= 12; k++) begin
`ifdef DMEM_DEBUG_PORT_EN
            dbgS0[k] = dbgRdata0;
            dbgS3[k] = dbgRdata3;
`endif
            if (valid0) begin
                pulses0++;
                if (lat0 == 0) lat0 = k;
                rd0 = rdata0;
                er0 = err0;
            end
            if (valid3) begin
                pulses3++;
                if (lat3 == 0) lat3 = k;
                rd3 = rdata3;
                er3 = err3;
            end
            @(negedge CLK);
        end
        checkOutput({tag, "/lat0"}, 32'(lat0), 32'(W0 + 1));
        checkOutput({tag, "/lat3"}, 32'(lat3), 32'(W3 + 1));
        checkOutput({tag, "/pulses0"}, 32'(pulses0), 32'd1);
        checkOutput({tag, "/pulses3"}, 32'(pulses3), 32'd1);
        checkOutput({tag, "/rdata0"}, rd0, exp0);
        checkOutput({tag, "/rdata3"}, rd3, exp3);
        checkOutput({tag, "/err0"}, 32'(er0), 32'(expErr));
        checkOutput({tag, "/err3"}, 32'(er3), 32'(expErr));
        checkOutput({tag, "/hold0"}, rdata0, exp0);
        if (we && !expErr) begin
            for (int d = 0; d < 2; d++) begin
                for (int i = 0; i < (1 << (int'(f3) % 4)); i++) begin
                    mdl[d][int'(addr) + i] = 8'(wd >> (8 * i));
                end
            end
        end
        obs0 = rd0;
        obs3 = rd3;
    endtask

    initial begin
        logic [31:0] o0, o3, old0, old3;
        int          pulses;
        RESET_N   = 1'b0;
        reqValid  = 1'b0;
        reqWe     = 1'b0;
        reqFunct3 = 3'd0;
        reqAddr   = 12'd0;
        reqWdata  = 32'd0;
`ifdef DMEM_DEBUG_PORT_EN
        dbgAddr   = 10'd8;
`endif
        repeat (3) @(negedge CLK);
        checkOutput("rst/valid0", 32'(valid0), 32'd0);
        checkOutput("rst/rdata0", rdata0, 32'd0);
        checkOutput("rst/err3", 32'(err3), 32'd0);
        checkOutput("rst/ready3", 32'(ready3), 32'd1);
`ifdef DMEM_DEBUG_PORT_EN
        checkOutput("rst/dbg0", dbgRdata0, 32'd0);
`endif
        RESET_N = 1'b1;
        @(negedge CLK);

        $display("[TB] directed byte/half/word accesses");
        applyStimulus(1'b1, F_W, 12'h010, 32'hDEADBEEF, "sw_010", o0, o3);
        applyStimulus(1'b0, F_W, 12'h010, 32'd0, "lw_010", o0, o3);
        checkOutput("lw_010_c0", o0, 32'hDEADBEEF);
        checkOutput("lw_010_c3", o3, 32'hDEADBEEF);
        applyStimulus(1'b1, F_B, 12'h013, 32'h12345680, "sb_013", o0, o3);
        applyStimulus(1'b0, F_B, 12'h013, 32'd0, "lb_013", o0, o3);
        checkOutput("lb_013_c", o0, 32'hFFFFFF80);
        applyStimulus(1'b0, F_BU, 12'h013, 32'd0, "lbu_013", o0, o3);
        checkOutput("lbu_013_c", o0, 32'h00000080);
        applyStimulus(1'b0, F_W, 12'h010, 32'd0, "lw_010b", o0, o3);
        checkOutput("lw_010b_c", o0, 32'h80ADBEEF);
        applyStimulus(1'b1, F_H, 12'h010, 32'hABCD1234, "sh_010", o0, o3);
        applyStimulus(1'b0, F_H, 12'h012, 32'd0, "lh_012", o0, o3);
        checkOutput("lh_012_c", o0, 32'hFFFF80AD);
        applyStimulus(1'b0, F_HU, 12'h012, 32'd0, "lhu_012", o0, o3);
        checkOutput("lhu_012_c", o3, 32'h000080AD);
        applyStimulus(1'b0, F_W, 12'h010, 32'd0, "lw_010c", o0, o3);
        checkOutput("lw_010c_c", o0, 32'h80AD1234);

        $display("[TB] error accesses");
        applyStimulus(1'b0, F_W, 12'h011, 32'd0, "lw_mis", o0, o3);
        applyStimulus(1'b1, F_H, 12'h015, 32'hFFFFFFFF, "sh_mis", o0, o3);
        applyStimulus(1'b1, F_W, 12'h016, 32'hFFFFFFFF, "sw_mis", o0, o3);
        applyStimulus(1'b0, 3'd3, 12'h010, 32'd0, "ld_f3_3", o0, o3);
        applyStimulus(1'b0, 3'd6, 12'h010, 32'd0, "ld_f3_6", o0, o3);
        applyStimulus(1'b1, 3'd5, 12'h010, 32'hFFFFFFFF, "st_f3_5", o0, o3);
        applyStimulus(1'b0, F_W, 12'h010, 32'd0, "lw_010d", o0, o3);
        checkOutput("lw_010d_c", o0, 32'h80AD1234);
        applyStimulus(1'b0, F_W, 12'h014, 32'd0, "lw_014_untouched", o0, o3);

        $display("[TB] top of address space");
        applyStimulus(1'b1, F_W, 12'hFFC, 32'hA5A50F0F, "sw_ffc", o0, o3);
        applyStimulus(1'b0, F_W, 12'hFFC, 32'd0, "lw_ffc", o0, o3);
        checkOutput("lw_ffc_c", o3, 32'hA5A50F0F);
        applyStimulus(1'b0, F_BU, 12'hFFF, 32'd0, "lbu_fff", o0, o3);
        checkOutput("lbu_fff_c", o0, 32'h000000A5);
        applyStimulus(1'b0, F_H, 12'hFFE, 32'd0, "lh_ffe", o0, o3);
        checkOutput("lh_ffe_c", o0, 32'hFFFFA5A5);

        $display("[TB] reset during wait states");
        applyStimulus(1'b1, F_W, 12'h020, 32'h11111111, "sw_020", o0, o3);
        applyStimulus(1'b0, F_W, 12'h020, 32'd0, "lw_020", o0, o3);
        reqValid  = 1'b1;
        reqWe     = 1'b1;
        reqFunct3 = F_W;
        reqAddr   = 12'h020;
        reqWdata  = 32'h55AA55AA;
        @(negedge CLK);
        RESET_N   = 1'b0;
        reqWdata  = 32'hBAD0BAD0;
        repeat (2) @(negedge CLK);
        reqValid  = 1'b0;
        RESET_N   = 1'b1;
        checkOutput("midrst/valid0", 32'(valid0), 32'd0);
        checkOutput("midrst/valid3", 32'(valid3), 32'd0);
        checkOutput("midrst/rdata0", rdata0, 32'd0);
        checkOutput("midrst/rdata3", rdata3, 32'd0);
        checkOutput("midrst/err3", 32'(err3), 32'd0);
        checkOutput("midrst/ready3", 32'(ready3), 32'd1);
        for (int i = 0; i < 4; i++) mdl[0][32 + i] = 8'(32'h55AA55AA >> (8 * i));
        @(negedge CLK);
        applyStimulus(1'b0, F_W, 12'h020, 32'd0, "lw_020_after_rst", o0, o3);
        checkOutput("abandon_c3", o3, 32'h11111111);
        checkOutput("commit_c0", o0, 32'h55AA55AA);

        $display("[TB] request held through wait states");
        reqValid  = 1'b1;
        reqWe     = 1'b0;
        reqFunct3 = F_W;
        reqAddr   = 12'h020;
        pulses    = 0;
        for (int i = 0; i < W3 + 2; i++) begin
            @(negedge CLK);
            if (valid3) pulses++;
        end
        reqValid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            if (valid3) pulses++;
        end
        checkOutput("held_valid_pulses3", 32'(pulses), 32'd1);

`ifdef DMEM_DEBUG_PORT_EN
        $display("[TB] debug read collision");
        old0 = {mdl[0][35], mdl[0][34], mdl[0][33], mdl[0][32]};
        old3 = {mdl[1][35], mdl[1][34], mdl[1][33], mdl[1][32]};
        applyStimulus(1'b1, F_W, 12'h020, 32'hCAFEF00D, "sw_dbg", o0, o3);
        checkOutput("dbg0_old", dbgS0[W0 + 1], old0);
        checkOutput("dbg0_new", dbgS0[W0 + 2], 32'hCAFEF00D);
        checkOutput("dbg3_old", dbgS3[W3 + 1], old3);
        checkOutput("dbg3_new", dbgS3[W3 + 2], 32'hCAFEF00D);
`else
        old0 = 32'd0;
        old3 = 32'd0;
`endif

        $display("[TB] randomized traffic");
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b1, F_W, 12'(12'h100 + 4 * i), $urandom, "rnd_init", o0, o3);
        end
        for (int i = 0; i < 60; i++) begin
            applyStimulus(1'($urandom), 3'($urandom), 12'(12'h100 + $urandom_range(63)), $urandom,
                          $sformatf("rnd%0d", i), o0, o3);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
